// File: rtl/ysyx_25030093_mem_pkg.sv
// Shared definitions for the memory responder: size codes, FSM states, byte-strobe helper.
// No logic of its own; imported by the responder top and its lane sub-module.
// Strobe helper returns 0 for the illegal size so an errored access touches no lane.
package ysyx_25030093_mem_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Byte strobe for an access of the given size at the given word offset.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] m;
    case (size)
      SZ_B:    m = 4'b0001 << off;
      SZ_H:    m = 4'b0011 << {off[1], 1'b0};
      SZ_W:    m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ysyx_25030093_mem_lane.sv
// Combinational store-merge and load-extract for one 32-bit memory word.
// Latency: zero cycles, purely combinational.
// No flow control; the caller decides when the merged word is written.
module ysyx_25030093_mem_lane
  import ysyx_25030093_mem_pkg::*;
(
  input  logic [31:0] i_old,
  input  logic [31:0] i_wdata,
  input  logic [3:0]  i_strb,
  input  logic [1:0]  i_off,
  output logic [31:0] o_merged,
  output logic [31:0] o_rdata
);

  logic [31:0] w_wsh;
  logic [31:0] w_rsh;
  logic [3:0]  w_rstrb;

  // Align store data up to its lanes, and the selected load lanes down to bit 0.
  assign w_wsh   = i_wdata << {i_off, 3'b000};
  assign w_rsh   = i_old >> {i_off, 3'b000};
  assign w_rstrb = i_strb >> i_off;

  // Strobed lanes take new data; load keeps only the strobed lanes, zero-extended.
  always_comb begin
    o_merged = i_old;
    o_rdata  = 32'd0;
    for (int i = 0; i < 4; i++) begin
      if (i_strb[i])  o_merged[8*i +: 8] = w_wsh[8*i +: 8];
      if (w_rstrb[i]) o_rdata[8*i +: 8]  = w_rsh[8*i +: 8];
    end
  end

endmodule

// File: rtl/ysyx_25030093_mem_resp.sv
// Memory responder for LSU loads/stores; one request in flight, optional host-memory backend (YSYX_25030093_MEM_DPI_EN).
// Latency: access commits LATENCY cycles after accept; rsp_valid is high from that edge on.
// Backpressure: req_ready only in IDLE; the response is held stable until rsp_ready is sampled high.
module ysyx_25030093_mem_resp
  import ysyx_25030093_mem_pkg::*;
#(
  parameter int          LATENCY   = 3,
  parameter int          MEM_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

`ifdef YSYX_25030093_MEM_DPI_EN
  logic [7:0] r_host [logic [31:0]];

  function automatic int paddr_read(input int raddr, input int len);
    logic [31:0] v;
    logic [31:0] a;
    v = 32'd0;
    for (int i = 0; i < len; i++) begin
      a = 32'(raddr) + 32'(i);
      if (r_host.exists(a)) v[8*i +: 8] = r_host[a];
    end
    return int'(v);
  endfunction

  function automatic void paddr_write(input int waddr, input int len, input int data);
    logic [31:0] d;
    d = 32'(data);
    for (int i = 0; i < len; i++) r_host[32'(waddr) + 32'(i)] = d[8*i +: 8];
  endfunction
`endif

  state_t      r_state;
  state_t      w_next_state;
  logic [3:0]  r_cnt;
  logic        r_wen;
  logic [1:0]  r_size;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_err;
  logic        w_commit;
  logic        w_misalign;
  logic        w_err;
  logic [3:0]  w_strb;
  logic [31:0] w_old;
  logic [31:0] w_merged;
  logic [31:0] w_ld;

  assign w_strb     = lane_mask(r_size, r_addr[1:0]);
  assign w_misalign = (r_size == SZ_H && r_addr[0]) ||
                      (r_size == SZ_W && r_addr[1:0] != 2'b00) ||
                      (r_size == 2'd3);

`ifdef YSYX_25030093_MEM_DPI_EN
  logic [31:0] w_len;
  logic [31:0] w_size_mask;

  // Host memory has no range limit; only alignment and size can fail.
  assign w_err       = w_misalign;
  assign w_len       = (r_size == SZ_B) ? 32'd1 : (r_size == SZ_H) ? 32'd2 : 32'd4;
  assign w_size_mask = (r_size == SZ_B) ? 32'h0000_00ff :
                       (r_size == SZ_H) ? 32'h0000_ffff : 32'hffff_ffff;
  assign w_old       = 32'd0;
`else
  localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  logic [31:0] r_mem [MEM_WORDS];
  logic [29:0] w_widx;
  logic        w_oor;

  // BASE_ADDR is word aligned, so the word index is a 30-bit subtract.
  assign w_widx = r_addr[31:2] - BASE_ADDR[31:2];
  assign w_oor  = (r_addr < BASE_ADDR) || ({2'b00, w_widx} >= 32'(MEM_WORDS));
  assign w_err  = w_misalign || w_oor;
  assign w_old  = r_mem[w_widx[AW-1:0]];

  // Store commits only at the WAIT->RESP edge, never under reset or on error.
  always_ff @(posedge clk) begin
    if (!rst && w_commit && !w_err && r_wen) r_mem[w_widx[AW-1:0]] <= w_merged;
  end
`endif

  ysyx_25030093_mem_lane u_lane (
    .i_old    (w_old),
    .i_wdata  (r_wdata),
    .i_strb   (w_strb),
    .i_off    (r_addr[1:0]),
    .o_merged (w_merged),
    .o_rdata  (w_ld)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  // Next state and handshake outputs, decoded from the registered state only.
  always_comb begin
    w_next_state = r_state;
    req_ready    = 1'b0;
    rsp_valid    = 1'b0;
    w_commit     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_next_state = ST_WAIT;
      end
      ST_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_commit     = 1'b1;
          w_next_state = ST_RESP;
        end
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Request capture, wait countdown and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= 4'd0;
      r_wen   <= 1'b0;
      r_size  <= 2'd0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      if (r_state == ST_IDLE && req_valid) begin
        r_wen   <= req_wen;
        r_size  <= req_size;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_cnt   <= 4'(LATENCY - 1);
      end else if (r_state == ST_WAIT && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_commit) begin
        r_err <= w_err;
`ifdef YSYX_25030093_MEM_DPI_EN
        r_rdata <= 32'd0;
        if (!w_err) begin
          if (r_wen) paddr_write(r_addr, w_len, r_wdata);
          else       r_rdata <= paddr_read(r_addr, w_len) & w_size_mask;
        end
`else
        r_rdata <= (w_err || r_wen) ? 32'd0 : w_ld;
`endif
      end
    end
  end

  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

endmodule
